pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5: register-file address width.
REQ-002 SHALL have parameter MEM_STAGES, default 1, legal 1..3: memory stages M1..MK between EX and WB (K = MEM_STAGES).
REQ-003 SHALL have derived width SEL_W = $clog2(MEM_STAGES+2).
REQ-004 SHALL have port i_clk, input, 1: clock, all logic on rising edge.
REQ-005 SHALL have port i_reset_n, input, 1: synchronous active-low reset.
REQ-006 SHALL have port i_if_valid, input, 1: fetch presents a valid instruction this cycle.
REQ-007 SHALL have ports i_id_rs1 and i_id_rs2, input, REG_ADDR_WIDTH: source registers of the ID instruction.
REQ-008 SHALL have ports i_id_rs1_used and i_id_rs2_used, input, 1: ID instruction reads that source.
REQ-009 SHALL have ports i_id_rd (input, REG_ADDR_WIDTH), i_id_rd_wr_en (input, 1) and i_id_is_load (input, 1).
REQ-010 SHALL have port i_ex_redirect, input, 1: taken branch or jump resolved in EX.
REQ-011 SHALL have ports o_pc_stall and o_if_id_stall, output, 1: hold PC and IF/ID register.
REQ-012 SHALL have port o_id_ex_bubble, output, 1: load a NOP (all control enables 0) into ID/EX.
REQ-013 SHALL have port o_if_id_flush, output, 1: invalidate IF/ID contents.
REQ-014 SHALL have ports o_fwd_a_sel and o_fwd_b_sel, output, SEL_W: EX operand source (0 = regfile, s = stage Ms result, K+1 = WB result).
REQ-015 SHALL have ports o_ex_valid (output, 1), o_commit (output, 1) and o_commit_rd (output, REG_ADDR_WIDTH).
REQ-016 SHALL have ports o_stall_cycles and o_flush_cycles, output, 32: performance counters.

Function
REQ-017 SHALL hold per-stage state {valid, rd, rd_wr_en, is_load} for ID, EX, M1..MK and WB; the ID stage holds valid only and takes rd, rd_wr_en and is_load from the inputs.
REQ-018 SHALL raise hazard H when ID is valid and any used source equals the rd of a valid, rd_wr_en, is_load instruction in EX or M1..M(K-1), with rd != 0.
REQ-019 SHALL, on H without redirect: assert o_pc_stall, o_if_id_stall and o_id_ex_bubble combinationally; hold ID valid; load a bubble into EX; advance EX..WB.
REQ-020 SHALL, on i_ex_redirect: assert o_if_id_flush and o_id_ex_bubble; next cycle, ID valid = 0 and EX valid = 0; redirect overrides H (stall outputs 0).
REQ-021 SHALL, otherwise, advance every stage each cycle: ID valid <= i_if_valid.
REQ-022 SHALL compute o_fwd_x_sel combinationally for the EX instruction: the lowest-index stage among M1..MK, WB that is valid, has rd_wr_en set and rd equal to that source; 0 if none matches, if rd == 0, or if EX is invalid.
REQ-023 SHALL never forward a load from M1..MK; H guarantees no such case exists.
REQ-024 SHALL rely on a write-first register file for the WB-to-ID same-cycle case; no select is generated for it.
REQ-025 SHALL drive o_commit = WB valid and o_commit_rd = WB rd, both registered; an instruction leaving ID at cycle t commits at cycle t+K+2.
REQ-026 SHALL ignore all ID inputs when ID is invalid.

Reset
REQ-027 SHALL, while i_reset_n = 0 at a clock edge, clear all stage valid, rd and flag state; every output reads 0 the following cycle.
REQ-028 SHALL apply reset mid-operation with no pending effects: in-flight instructions never commit.

Configuration
REQ-029 SHALL, with PIPE_HAZARD_CTRL_PERF_CNT_EN defined, count o_stall_cycles (+1 per cycle with o_pc_stall) and o_flush_cycles (+1 per cycle with o_if_id_flush); both clear on reset and saturate at 0xFFFFFFFF.
REQ-030 SHALL, without PIPE_HAZARD_CTRL_PERF_CNT_EN, tie both counter ports to constant 0 and infer no counter flops.

Verification
REQ-031 K=1: add x5 then add rs1=x5 -> no stall; consumer in EX sees o_fwd_a_sel=1.
REQ-032 K=1: lw x6 then add rs2=x6 -> o_pc_stall high for exactly 1 cycle; consumer in EX sees o_fwd_b_sel=2.
REQ-033 K=3: lw x7 then sub rs1=x7 -> 3 stall cycles; then o_fwd_a_sel=4.
REQ-034 Producer rd=x0, consumer rs1=x0 -> o_fwd_a_sel=0, no stall, even when the producer is a load.
REQ-035 i_ex_redirect in the same cycle as H -> o_pc_stall=0, o_if_id_flush=1; o_commit low for 2 cycles at the point where the flushed instructions would have committed.
REQ-036 Reset asserted with 4 valid in-flight instructions -> o_commit=0 thereafter until new instructions pass; with the macro defined, both counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for an in-order pipeline: load-use stall, EX redirect flush and EX operand forwarding.
// Optional stall/flush performance counters are enabled by defining PIPE_HAZARD_CTRL_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int  REG_ADDR_WIDTH = 5,
   parameter int  MEM_STAGES     = 1,
   localparam int SEL_W          = $clog2(MEM_STAGES + 2)
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      i_if_valid,
   input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2,
   input  logic                      i_id_rs1_used,
   input  logic                      i_id_rs2_used,
   input  logic [REG_ADDR_WIDTH-1:0] i_id_rd,
   input  logic                      i_id_rd_wr_en,
   input  logic                      i_id_is_load,
   input  logic                      i_ex_redirect,
   output logic                      o_pc_stall,
   output logic                      o_if_id_stall,
   output logic                      o_id_ex_bubble,
   output logic                      o_if_id_flush,
   output logic [SEL_W-1:0]          o_fwd_a_sel,
   output logic [SEL_W-1:0]          o_fwd_b_sel,
   output logic                      o_ex_valid,
   output logic                      o_commit,
   output logic [REG_ADDR_WIDTH-1:0] o_commit_rd,
   output logic [31:0]               o_stall_cycles,
   output logic [31:0]               o_flush_cycles
);

   // Stage index 0 = EX, 1..MEM_STAGES = M1..MK, MEM_STAGES+1 = WB
   localparam int NST = MEM_STAGES + 2;
   localparam int WB  = NST - 1;

   logic                      id_valid_q, id_valid_d;
   logic [NST-1:0]            st_valid_q, st_valid_d;
   logic [NST-1:0]            st_wr_q, st_wr_d;
   logic [NST-1:0]            st_ld_q, st_ld_d;
   logic [REG_ADDR_WIDTH-1:0] st_rd_q [NST];
   logic [REG_ADDR_WIDTH-1:0] st_rd_d [NST];
   logic [REG_ADDR_WIDTH-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
   logic                      ex_rs1_used_q, ex_rs1_used_d, ex_rs2_used_q, ex_rs2_used_d;
   logic                      hazard_s;
   logic [SEL_W-1:0]          fwd_a_s, fwd_b_s;
   logic                      unused_ld_s;

   // Load results are only needed before they reach MK; later copies exist for stage bookkeeping only.
   assign unused_ld_s = ^st_ld_q[WB:MEM_STAGES];

   // Load-use hazard: a load in EX..M(K-1) whose result the ID instruction reads
   always_comb begin
      hazard_s = 1'b0;
      for (int s = 0; s < MEM_STAGES; s++) begin
         if (st_valid_q[s] && st_wr_q[s] && st_ld_q[s] && (st_rd_q[s] != '0) &&
             ((i_id_rs1_used && (i_id_rs1 == st_rd_q[s])) ||
              (i_id_rs2_used && (i_id_rs2 == st_rd_q[s])))) begin
            hazard_s = 1'b1;
         end else begin
            hazard_s = hazard_s;
         end
      end
      if (!id_valid_q) begin
         hazard_s = 1'b0;
      end else begin
         hazard_s = hazard_s;
      end
   end

   assign o_pc_stall     = hazard_s & ~i_ex_redirect;
   assign o_if_id_stall  = hazard_s & ~i_ex_redirect;
   assign o_id_ex_bubble = hazard_s | i_ex_redirect;
   assign o_if_id_flush  = i_ex_redirect;

   // Pipeline advance with bubble insertion on stall or redirect
   always_comb begin
      id_valid_d    = i_if_valid;
      st_valid_d[0] = id_valid_q;
      st_wr_d[0]    = id_valid_q & i_id_rd_wr_en;
      st_ld_d[0]    = id_valid_q & i_id_is_load;
      st_rd_d[0]    = id_valid_q ? i_id_rd : '0;
      ex_rs1_d      = id_valid_q ? i_id_rs1 : '0;
      ex_rs2_d      = id_valid_q ? i_id_rs2 : '0;
      ex_rs1_used_d = id_valid_q & i_id_rs1_used;
      ex_rs2_used_d = id_valid_q & i_id_rs2_used;
      for (int s = 1; s < NST; s++) begin
         st_valid_d[s] = st_valid_q[s-1];
         st_wr_d[s]    = st_wr_q[s-1];
         st_ld_d[s]    = st_ld_q[s-1];
         st_rd_d[s]    = st_rd_q[s-1];
      end
      if (i_ex_redirect || hazard_s) begin
         id_valid_d    = i_ex_redirect ? 1'b0 : id_valid_q;
         st_valid_d[0] = 1'b0;
         st_wr_d[0]    = 1'b0;
         st_ld_d[0]    = 1'b0;
         st_rd_d[0]    = '0;
         ex_rs1_d      = '0;
         ex_rs2_d      = '0;
         ex_rs1_used_d = 1'b0;
         ex_rs2_used_d = 1'b0;
      end else begin
         id_valid_d = i_if_valid;
      end
   end

   // Stage state registers
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         id_valid_q    <= 1'b0;
         st_valid_q    <= '0;
         st_wr_q       <= '0;
         st_ld_q       <= '0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_rs1_used_q <= 1'b0;
         ex_rs2_used_q <= 1'b0;
         for (int s = 0; s < NST; s++) begin
            st_rd_q[s] <= '0;
         end
      end else begin
         id_valid_q    <= id_valid_d;
         st_valid_q    <= st_valid_d;
         st_wr_q       <= st_wr_d;
         st_ld_q       <= st_ld_d;
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
         ex_rs1_used_q <= ex_rs1_used_d;
         ex_rs2_used_q <= ex_rs2_used_d;
         for (int s = 0; s < NST; s++) begin
            st_rd_q[s] <= st_rd_d[s];
         end
      end
   end

   // Forwarding: scan from WB down so the youngest (lowest-index) producer wins
   always_comb begin
      fwd_a_s = '0;
      fwd_b_s = '0;
      for (int s = WB; s >= 1; s--) begin
         if (st_valid_q[s] && st_wr_q[s] && (st_rd_q[s] == ex_rs1_q)) begin
            fwd_a_s = SEL_W'(s);
         end else begin
            fwd_a_s = fwd_a_s;
         end
         if (st_valid_q[s] && st_wr_q[s] && (st_rd_q[s] == ex_rs2_q)) begin
            fwd_b_s = SEL_W'(s);
         end else begin
            fwd_b_s = fwd_b_s;
         end
      end
      if (!st_valid_q[0] || !ex_rs1_used_q || (ex_rs1_q == '0)) begin
         fwd_a_s = '0;
      end else begin
         fwd_a_s = fwd_a_s;
      end
      if (!st_valid_q[0] || !ex_rs2_used_q || (ex_rs2_q == '0)) begin
         fwd_b_s = '0;
      end else begin
         fwd_b_s = fwd_b_s;
      end
   end

   assign o_fwd_a_sel = fwd_a_s;
   assign o_fwd_b_sel = fwd_b_s;
   assign o_ex_valid  = st_valid_q[0];
   assign o_commit    = st_valid_q[WB];
   assign o_commit_rd = st_rd_q[WB];

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   // Saturating event counters
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (o_pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (o_if_id_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Counter registers
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign o_stall_cycles = stall_cnt_q;
   assign o_flush_cycles = flush_cnt_q;
`else
   assign o_stall_cycles = 32'd0;
   assign o_flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instance 0 uses MEM_STAGES=1, instance 1 uses MEM_STAGES=3.
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic       if_valid [2];
   logic [4:0] id_rs1 [2];
   logic [4:0] id_rs2 [2];
   logic       id_rs1_used [2];
   logic       id_rs2_used [2];
   logic [4:0] id_rd [2];
   logic       id_wr [2];
   logic       id_ld [2];
   logic       redirect [2];
   logic       pc_stall [2];
   logic       if_id_stall [2];
   logic       bubble [2];
   logic       flush [2];
   logic       ex_valid [2];
   logic       commit [2];
   logic [4:0] commit_rd [2];
   logic [31:0] stall_cnt [2];
   logic [31:0] flush_cnt [2];
   logic [1:0] fa1, fb1;
   logic [2:0] fa3, fb3;
   int         n_checks;
   int         n_errors;

   pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .MEM_STAGES(1)) u_dut_k1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_if_valid(if_valid[0]),
      .i_id_rs1(id_rs1[0]), .i_id_rs2(id_rs2[0]),
      .i_id_rs1_used(id_rs1_used[0]), .i_id_rs2_used(id_rs2_used[0]),
      .i_id_rd(id_rd[0]), .i_id_rd_wr_en(id_wr[0]), .i_id_is_load(id_ld[0]),
      .i_ex_redirect(redirect[0]),
      .o_pc_stall(pc_stall[0]), .o_if_id_stall(if_id_stall[0]),
      .o_id_ex_bubble(bubble[0]), .o_if_id_flush(flush[0]),
      .o_fwd_a_sel(fa1), .o_fwd_b_sel(fb1),
      .o_ex_valid(ex_valid[0]), .o_commit(commit[0]), .o_commit_rd(commit_rd[0]),
      .o_stall_cycles(stall_cnt[0]), .o_flush_cycles(flush_cnt[0])
   );

   pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .MEM_STAGES(3)) u_dut_k3 (
      .i_clk(clk), .i_reset_n(rst_n), .i_if_valid(if_valid[1]),
      .i_id_rs1(id_rs1[1]), .i_id_rs2(id_rs2[1]),
      .i_id_rs1_used(id_rs1_used[1]), .i_id_rs2_used(id_rs2_used[1]),
      .i_id_rd(id_rd[1]), .i_id_rd_wr_en(id_wr[1]), .i_id_is_load(id_ld[1]),
      .i_ex_redirect(redirect[1]),
      .o_pc_stall(pc_stall[1]), .o_if_id_stall(if_id_stall[1]),
      .o_id_ex_bubble(bubble[1]), .o_if_id_flush(flush[1]),
      .o_fwd_a_sel(fa3), .o_fwd_b_sel(fb3),
      .o_ex_valid(ex_valid[1]), .o_commit(commit[1]), .o_commit_rd(commit_rd[1]),
      .o_stall_cycles(stall_cnt[1]), .o_flush_cycles(flush_cnt[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cycle on instance d: apply inputs just after the rising edge, return at the falling edge.
   task automatic cyc(input int d, input logic ifv,
                      input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic ld, input logic rdr);
      @(posedge clk);
      #1;
      if_valid[d]    = ifv;
      id_rs1[d]      = r1;
      id_rs1_used[d] = u1;
      id_rs2[d]      = r2;
      id_rs2_used[d] = u2;
      id_rd[d]       = rd;
      id_wr[d]       = we;
      id_ld[d]       = ld;
      redirect[d]    = rdr;
      @(negedge clk);
   endtask

   task automatic idle(input int d);
      cyc(d, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      for (int d = 0; d < 2; d++) begin
         if_valid[d] = 1'b0; id_rs1[d] = 5'd0; id_rs2[d] = 5'd0;
         id_rs1_used[d] = 1'b0; id_rs2_used[d] = 1'b0; id_rd[d] = 5'd0;
         id_wr[d] = 1'b0; id_ld[d] = 1'b0; redirect[d] = 1'b0;
      end

      // Reset state
      idle(0);
      idle(0);
      for (int d = 0; d < 2; d++) begin
         check("rst_ex_valid", 32'(ex_valid[d]), 32'd0);
         check("rst_commit", 32'(commit[d]), 32'd0);
         check("rst_commit_rd", 32'(commit_rd[d]), 32'd0);
         check("rst_pc_stall", 32'(pc_stall[d]), 32'd0);
         check("rst_stall_cnt", stall_cnt[d], 32'd0);
      end
      check("rst_fa1", 32'(fa1), 32'd0);
      check("rst_fa3", 32'(fa3), 32'd0);
      rst_n = 1'b1;

      // K=1: ALU producer x5 feeding rs1
      cyc(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      check("alu_stall_c1", 32'(pc_stall[0]), 32'd0);
      cyc(0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      check("alu_stall_c2", 32'(pc_stall[0]), 32'd0);
      idle(0);
      check("alu_fwd_a", 32'(fa1), 32'd1);
      check("alu_fwd_b", 32'(fb1), 32'd0);
      check("alu_ex_valid", 32'(ex_valid[0]), 32'd1);
      idle(0);
      check("alu_commit_p", 32'(commit[0]), 32'd1);
      check("alu_commit_rd_p", 32'(commit_rd[0]), 32'd5);
      idle(0);
      check("alu_commit_rd_c", 32'(commit_rd[0]), 32'd8);
      repeat (3) idle(0);

      // K=1: lw x6 then rs2=x6
      cyc(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
      cyc(0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      check("lu_stall", 32'(pc_stall[0]), 32'd1);
      check("lu_ifid_stall", 32'(if_id_stall[0]), 32'd1);
      check("lu_bubble", 32'(bubble[0]), 32'd1);
      check("lu_flush", 32'(flush[0]), 32'd0);
      cyc(0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      check("lu_stall_end", 32'(pc_stall[0]), 32'd0);
      check("lu_bubble_end", 32'(bubble[0]), 32'd0);
      idle(0);
      check("lu_fwd_b", 32'(fb1), 32'd2);
      check("lu_fwd_a", 32'(fa1), 32'd0);
      check("lu_ex_valid", 32'(ex_valid[0]), 32'd1);
      check("lu_commit_rd", 32'(commit_rd[0]), 32'd6);
      idle(0);
      check("lu_commit_bubble", 32'(commit[0]), 32'd0);
      idle(0);
      check("lu_commit_c", 32'(commit[0]), 32'd1);
      check("lu_commit_rd_c", 32'(commit_rd[0]), 32'd9);
      repeat (3) idle(0);

      // K=1: load to x0 then rs1=x0
      cyc(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      cyc(0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
      check("x0_stall", 32'(pc_stall[0]), 32'd0);
      idle(0);
      check("x0_fwd_a", 32'(fa1), 32'd0);
      check("x0_ex_valid", 32'(ex_valid[0]), 32'd1);
      repeat (3) idle(0);

      // K=1: redirect in the same cycle as a load-use hazard
      cyc(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
      cyc(0, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1);
      check("rd_pc_stall", 32'(pc_stall[0]), 32'd0);
      check("rd_ifid_stall", 32'(if_id_stall[0]), 32'd0);
      check("rd_flush", 32'(flush[0]), 32'd1);
      check("rd_bubble", 32'(bubble[0]), 32'd1);
      idle(0);
      check("rd_ex_valid", 32'(ex_valid[0]), 32'd0);
      idle(0);
      check("rd_commit_lw", 32'(commit[0]), 32'd1);
      check("rd_commit_rd_lw", 32'(commit_rd[0]), 32'd10);
      idle(0);
      check("rd_commit_gap1", 32'(commit[0]), 32'd0);
      idle(0);
      check("rd_commit_gap2", 32'(commit[0]), 32'd0);
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
      check("k1_stall_cnt", stall_cnt[0], 32'd1);
      check("k1_flush_cnt", flush_cnt[0], 32'd1);
`else
      check("k1_stall_cnt", stall_cnt[0], 32'd0);
      check("k1_flush_cnt", flush_cnt[0], 32'd0);
`endif

      // K=3: lw x7 then rs1=x7
      cyc(1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc(1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
         check("k3_stall", 32'(pc_stall[1]), 32'd1);
      end
      cyc(1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
      check("k3_stall_end", 32'(pc_stall[1]), 32'd0);
      idle(1);
      check("k3_fwd_a", 32'(fa3), 32'd4);
      check("k3_ex_valid", 32'(ex_valid[1]), 32'd1);
      check("k3_commit_lw", 32'(commit[1]), 32'd1);
      check("k3_commit_rd_lw", 32'(commit_rd[1]), 32'd7);
      idle(1);
      check("k3_commit_bubble", 32'(commit[1]), 32'd0);
      repeat (2) idle(1);
      idle(1);
      check("k3_commit_sub", 32'(commit[1]), 32'd1);
      check("k3_commit_rd_sub", 32'(commit_rd[1]), 32'd11);
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
      check("k3_stall_cnt", stall_cnt[1], 32'd3);
`else
      check("k3_stall_cnt", stall_cnt[1], 32'd0);
`endif
      repeat (2) idle(1);

      // K=3: reset with four instructions in flight
      cyc(1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, (i < 3) ? 1'b1 : 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'(12 + i), 1'b1, 1'b0, 1'b0);
      end
      check("fl_ex_valid", 32'(ex_valid[1]), 32'd1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      check("fl_rst_ex_valid", 32'(ex_valid[1]), 32'd0);
      for (int d = 0; d < 2; d++) begin
         check("fl_rst_stall_cnt", stall_cnt[d], 32'd0);
         check("fl_rst_flush_cnt", flush_cnt[d], 32'd0);
      end
      for (int i = 0; i < 8; i++) begin
         idle(1);
         check("fl_no_commit", 32'(commit[1]), 32'd0);
      end
      cyc(1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc(1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         idle(1);
         check("new_wait", 32'(commit[1]), 32'd0);
      end
      idle(1);
      check("new_commit", 32'(commit[1]), 32'd1);
      check("new_commit_rd", 32'(commit_rd[1]), 32'd20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
